// File: rtl/fxp_to_dec_pkg.sv
// Shared definitions for the fixed-point to decimal (BCD) converter.
//   - Default width constants for the converter parameters.
//   - bcd_digit_t: one packed BCD digit.
//   - state_t: converter FSM states.
package fxp_pkg;

    localparam int WHOLE_WIDTH_DEF     = 16;
    localparam int FRACTION_WIDTH_DEF  = 16;
    localparam int WHOLE_DIGITS_DEF    = 5;
    localparam int FRACTION_DIGITS_DEF = 5;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        WHOLE,
        FRAC,
        DONE
    } state_t;

endpackage

// File: rtl/fxp_to_dec_bcd_adjust.sv
// Double-dabble digit correction, purely combinational.
// Ports:
//   in_digit   in   4   current BCD digit
//   out_digit  out  4   digit + 3 when it is 5 or more, otherwise unchanged
module bcd_adjust
    import fxp_pkg::*;
(
    input  bcd_digit_t in_digit,
    output bcd_digit_t out_digit
);

    assign out_digit = (in_digit >= 4'd5) ? (in_digit + 4'd3) : in_digit;

endmodule

// File: rtl/fxp_to_dec.sv
// Sequential converter from unsigned (or, optionally, two's complement)
// Q(wholeWidth).(fractionWidth) fixed point to packed BCD digits.
// The whole part is converted with double-dabble (one bit per cycle), the
// fraction with repeated multiply-by-10 and truncation (one digit per cycle).
//
// Optional build macro: FXP_TO_DEC_SIGNED_EN -- treat value as two's
// complement; isNegative reports the sign and the magnitude is converted.
//
// Ports:
//   clock        in   1                         rising-edge clock
//   reset        in   1                         synchronous, active-high
//   convert_en   in   1                         start request, taken only while ready=1
//   value        in   wholeWidth+fractionWidth  fixed-point operand
//   ready        out  1                         high in IDLE only
//   done         out  1                         one-cycle pulse, results valid
//   isNegative   out  1                         sign of the converted value
//   wholeBcd     out  4*wholeDigits             packed BCD, digit 0 in [3:0]
//   fractionBcd  out  4*fractionDigits          packed BCD, first fraction digit in MS nibble
module fxp_to_dec
    import fxp_pkg::*;
#(
    parameter int wholeWidth     = WHOLE_WIDTH_DEF,
    parameter int fractionWidth  = FRACTION_WIDTH_DEF,
    parameter int wholeDigits    = WHOLE_DIGITS_DEF,
    parameter int fractionDigits = FRACTION_DIGITS_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 convert_en,
    input  logic [wholeWidth+fractionWidth-1:0]  value,
    output logic                                 ready,
    output logic                                 done,
    output logic                                 isNegative,
    output logic [4*wholeDigits-1:0]             wholeBcd,
    output logic [4*fractionDigits-1:0]          fractionBcd
);

    localparam int VAL_W = wholeWidth + fractionWidth;
    localparam int WB_W  = 4 * wholeDigits;
    localparam int FB_W  = 4 * fractionDigits;
    localparam int CNT_W = $clog2(((wholeWidth > fractionDigits) ? wholeWidth : fractionDigits) + 1);
    localparam int PROD_W = fractionWidth + 4;

    // Control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    // Scratch datapath
    logic [wholeWidth-1:0]    whole_q, whole_d;
    logic [fractionWidth-1:0] frac_q, frac_d;
    logic [WB_W-1:0]          wbcd_q, wbcd_d;
    logic [FB_W-1:0]          fbcd_q, fbcd_d;
    logic                     sign_q, sign_d;

    // Registered results
    logic                     neg_out_q, neg_out_d;
    logic [WB_W-1:0]          whole_out_q, whole_out_d;
    logic [FB_W-1:0]          frac_out_q, frac_out_d;

    logic [WB_W-1:0]          wbcd_adj;
    logic [PROD_W-1:0]        prod;
    logic [VAL_W-1:0]         mag;
    logic                     sign_cap;

    for (genvar i = 0; i < wholeDigits; i++) begin : g_adj
        bcd_adjust u_adj (
            .in_digit  (wbcd_q[4*i +: 4]),
            .out_digit (wbcd_adj[4*i +: 4])
        );
    end

`ifdef FXP_TO_DEC_SIGNED_EN
    // Negating the most negative value wraps back onto itself, which read as
    // unsigned is exactly its magnitude.
    assign sign_cap = value[VAL_W-1];
    assign mag      = sign_cap ? (~value + VAL_W'(1)) : value;
`else
    assign sign_cap = 1'b0;
    assign mag      = value;
`endif

    // f*10 as (f<<3)+(f<<1); the top nibble is the next decimal digit.
    assign prod = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        whole_d     = whole_q;
        frac_d      = frac_q;
        wbcd_d      = wbcd_q;
        fbcd_d      = fbcd_q;
        sign_d      = sign_q;
        neg_out_d   = neg_out_q;
        whole_out_d = whole_out_q;
        frac_out_d  = frac_out_q;

        unique case (state_q)
            IDLE: begin
                if (convert_en) begin
                    whole_d = mag[VAL_W-1:fractionWidth];
                    frac_d  = mag[fractionWidth-1:0];
                    sign_d  = sign_cap;
                    wbcd_d  = '0;
                    fbcd_d  = '0;
                    cnt_d   = '0;
                    state_d = WHOLE;
                end
            end
            WHOLE: begin
                wbcd_d  = {wbcd_adj[WB_W-2:0], whole_q[wholeWidth-1]};
                whole_d = {whole_q[wholeWidth-2:0], 1'b0};
                if (cnt_q == CNT_W'(wholeWidth - 1)) begin
                    cnt_d   = '0;
                    state_d = FRAC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FRAC: begin
                fbcd_d = {fbcd_q[FB_W-5:0], prod[PROD_W-1 -: 4]};
                frac_d = prod[fractionWidth-1:0];
                if (cnt_q == CNT_W'(fractionDigits - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Results land in the output registers together with the
                // done pulse, as the FSM returns to IDLE.
                done_d      = 1'b1;
                neg_out_d   = sign_q;
                whole_out_d = wbcd_q;
                frac_out_d  = fbcd_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            neg_out_q   <= 1'b0;
            whole_out_q <= '0;
            frac_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            neg_out_q   <= neg_out_d;
            whole_out_q <= whole_out_d;
            frac_out_q  <= frac_out_d;
        end
    end

    // Scratch is always reloaded on acceptance, so it needs no reset.
    always_ff @(posedge clock) begin
        whole_q <= whole_d;
        frac_q  <= frac_d;
        wbcd_q  <= wbcd_d;
        fbcd_q  <= fbcd_d;
        sign_q  <= sign_d;
    end

    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign isNegative  = neg_out_q;
    assign wholeBcd    = whole_out_q;
    assign fractionBcd = frac_out_q;

endmodule

// File: tb/tb_fxp_to_dec.sv
module tb_fxp_to_dec;

    logic        clock = 1'b0;
    logic        reset;
    logic        convert_en;
    logic [31:0] value;
    logic        ready;
    logic        done;
    logic        isNegative;
    logic [19:0] wholeBcd;
    logic [19:0] fractionBcd;

    fxp_to_dec dut (
        .clock       (clock),
        .reset       (reset),
        .convert_en  (convert_en),
        .value       (value),
        .ready       (ready),
        .done        (done),
        .isNegative  (isNegative),
        .wholeBcd    (wholeBcd),
        .fractionBcd (fractionBcd)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [19:0] w;
        logic [19:0] f;
        logic        n;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   done_cyc_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   dones    = 0;
    int   accepts  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Acceptance logger and scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset && convert_en && ready) begin
            acc_q.push_back(cyc + 1);
            accepts++;
        end
        if (done) begin
            exp_t e;
            int   a;
            dones++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wholeBcd", wholeBcd, e.w);
                check("fractionBcd", fractionBcd, e.f);
                check("isNegative", isNegative, e.n);
                check("ready_with_done", ready, 1);
            end
            if (acc_q.size() != 0) begin
                a = acc_q.pop_front();
                check("latency", cyc - a, 22);
            end else begin
                check("accept_logged", 32'd0, 32'd1);
            end
            for (int i = 0; i < 5; i++) begin
                check("whole_digit_le9", (wholeBcd[4*i +: 4] <= 4'd9), 1);
                check("frac_digit_le9", (fractionBcd[4*i +: 4] <= 4'd9), 1);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic convert(input logic [31:0] v, input exp_t e);
        int n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        check("ready_before_start", ready, 1);
        value      = v;
        convert_en = 1'b1;
        exp_q.push_back(e);
        step();
        convert_en = 1'b0;
        value      = ~v;
        check("ready_low_after_accept", ready, 0);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (dones < target && n < 200) begin
            step();
            n++;
        end
        check("done_count", dones, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int a0;
        int n;
        int sz;
        reset      = 1'b1;
        convert_en = 1'b0;
        value      = '0;
        step();
        step();
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_neg", isNegative, 0);
        check("reset_whole", wholeBcd, 0);
        check("reset_frac", fractionBcd, 0);
        reset = 1'b0;
        step();

        convert(32'h0003_2426, '{w: 20'h00003, f: 20'h14120, n: 1'b0});
        wait_done(1);

`ifdef FXP_TO_DEC_SIGNED_EN
        convert(32'hFFFF_8000, '{w: 20'h00000, f: 20'h50000, n: 1'b1});
        wait_done(2);
        convert(32'h8000_0000, '{w: 20'h32768, f: 20'h00000, n: 1'b1});
        wait_done(3);
`else
        convert(32'hFFFF_FFFF, '{w: 20'h65535, f: 20'h99998, n: 1'b0});
        wait_done(2);
        convert(32'h0001_0000, '{w: 20'h00001, f: 20'h00000, n: 1'b0});
        wait_done(3);
`endif

        convert(32'h0000_8000, '{w: 20'h00000, f: 20'h50000, n: 1'b0});
        wait_done(4);
        convert(32'h0000_0000, '{w: 20'h00000, f: 20'h00000, n: 1'b0});
        wait_done(5);

        // Extra start request in the middle of a conversion is ignored.
        convert(32'h0000_4000, '{w: 20'h00000, f: 20'h25000, n: 1'b0});
        step(); step(); step();
        convert_en = 1'b1;
        step();
        convert_en = 1'b0;
        wait_done(6);
        for (int i = 0; i < 30; i++) step();
        check("single_done", dones, 6);

        // Held request: back-to-back conversions every 23 clocks.
        d0 = dones;
        a0 = accepts;
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{w: 20'h00000, f: 20'h50000, n: 1'b0});
        value      = 32'h0000_8000;
        convert_en = 1'b1;
        n = 0;
        while (accepts < a0 + 3 && n < 200) begin
            step();
            n++;
        end
        convert_en = 1'b0;
        check("b2b_accepts", accepts, a0 + 3);
        wait_done(d0 + 3);
        sz = done_cyc_q.size();
        if (sz >= 3) begin
            check("b2b_spacing_1", done_cyc_q[sz-2] - done_cyc_q[sz-3], 23);
            check("b2b_spacing_2", done_cyc_q[sz-1] - done_cyc_q[sz-2], 23);
        end else begin
            check("b2b_done_records", sz, 3);
        end

        // Reset in the middle of a conversion aborts with no done.
        d0 = dones;
        convert(32'h0003_2426, '{w: 20'h00003, f: 20'h14120, n: 1'b0});
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        step();
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_whole", wholeBcd, 0);
        check("abort_frac", fractionBcd, 0);
        check("abort_neg", isNegative, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("no_done_after_abort", dones, d0);

        convert(32'h0003_2426, '{w: 20'h00003, f: 20'h14120, n: 1'b0});
        wait_done(d0 + 1);
        step();
        check("done_is_pulse", done, 0);
        check("result_held", wholeBcd, 20'h00003);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
